wall_clock_display: RTL and testbench

- Downstream consumer of the WallClock counter outputs (seconds, minutes, hours).
- Drives a 4-digit multiplexed common-anode 7-segment display on the fast board clock.
- Snapshots the time once per scan frame and converts two binary fields to BCD with a sequential double-dabble engine.
- Decodes the BCD digits to segments and scans the four digits.
- Shows HH:MM or MM:SS. Digit 2's decimal point is the blinking colon.

---
 rtl/wall_clock_display.sv | 245 ++++++++++++++++++++++++
 tb/tb_wall_clock_display.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wall_clock_display.sv
// -----------------------------------------------------------------------------
// wall_clock_display
//
// Purpose:
//   Drives a 4-digit multiplexed common-anode 7-segment display from the binary
//   time fields of the WallClock counter. Once per scan frame the time is
//   snapshotted, the two shown fields are converted to BCD by a sequential
//   double-dabble engine, and the committed digits are scanned one per slot.
//   Shows HH:MM (show_seconds=0) or MM:SS (show_seconds=1). The decimal point
//   of digit 2 is the blinking colon. It is lit on even seconds.
//
// Ports:
//   Clock          in   1  board clock; every register is clocked here
//   reset          in   1  synchronous, active-high reset
//   seconds        in   6  binary seconds
//   minutes        in   6  binary minutes
//   hours          in   5  binary hours
//   show_seconds   in   1  0 = HH:MM, 1 = MM:SS (sampled at frame start only)
//   SegmentDrivers out  8  active-low segments {dp,g,f,e,d,c,b,a}
//   SegmentSelect  out  4  active-low digit enables, bit n = digit n (0 = right)
//
// States:
//   S_IDLE   | wait for frame start, snapshot inputs
//   S_CONV_L | 6 double-dabble steps on the left field
//   S_CONV_R | 6 double-dabble steps on the right field
//   S_COMMIT | write all four digits and colon at once, set valid
// -----------------------------------------------------------------------------
module wall_clock_display #(
    parameter int SCAN_DIV   = 100000,
    parameter bit LEAD_BLANK = 1'b0
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       show_seconds,
    output logic [7:0] SegmentDrivers,
    output logic [3:0] SegmentSelect
);

    localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]      LAST_BIT = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV_L,
        S_CONV_R,
        S_COMMIT
    } state_t;

    state_t        state_q,      state_d;
    logic [CW-1:0] scan_cnt_q,   scan_cnt_d;
    logic [1:0]    digit_idx_q,  digit_idx_d;
    logic [5:0]    shift_q,      shift_d;
    logic [5:0]    r_snap_q,     r_snap_d;
    logic          colon_snap_q, colon_snap_d;
    logic [7:0]    bcd_q,        bcd_d;
    logic [7:0]    l_bcd_q,      l_bcd_d;
    logic [2:0]    bit_cnt_q,    bit_cnt_d;
    logic [3:0]    d3_q,         d3_d;
    logic [3:0]    d2_q,         d2_d;
    logic [3:0]    d1_q,         d1_d;
    logic [3:0]    d0_q,         d0_d;
    logic          colon_q,      colon_d;
    logic          valid_q,      valid_d;
    logic [7:0]    seg_q,        seg_d;
    logic [3:0]    sel_q,        sel_d;

    logic          frame_start;
    logic [7:0]    bcd_next;
    logic [3:0]    cur_nibble;

    // One double-dabble step: correct nibbles >= 5, then shift in the next bit.
    // A 6-bit input never carries out of the tens nibble, so bit 7 is dropped.
    function automatic logic [7:0] bcd_step(input logic [7:0] bcd, input logic in_bit);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        return {adj[6:0], in_bit};
    endfunction

    // Active-low segment pattern with dp off; 10..15 blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    assign frame_start = (scan_cnt_q == '0) && (digit_idx_q == 2'd0);
    assign bcd_next    = bcd_step(bcd_q, shift_q[5]);

    always_comb begin
        state_d      = state_q;
        scan_cnt_d   = scan_cnt_q;
        digit_idx_d  = digit_idx_q;
        shift_d      = shift_q;
        r_snap_d     = r_snap_q;
        colon_snap_d = colon_snap_q;
        bcd_d        = bcd_q;
        l_bcd_d      = l_bcd_q;
        bit_cnt_d    = bit_cnt_q;
        d3_d         = d3_q;
        d2_d         = d2_q;
        d1_d         = d1_q;
        d0_d         = d0_q;
        colon_d      = colon_q;
        valid_d      = valid_q;
        seg_d        = 8'hFF;
        sel_d        = 4'b1111;
        cur_nibble   = 4'd0;

        // Scan timing
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end else begin
            scan_cnt_d  = scan_cnt_q + CW'(1);
        end

        // Snapshot / conversion FSM
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    shift_d      = show_seconds ? minutes : {1'b0, hours};
                    r_snap_d     = show_seconds ? seconds : minutes;
                    colon_snap_d = ~seconds[0];
                    bcd_d        = 8'd0;
                    bit_cnt_d    = 3'd0;
                    state_d      = S_CONV_L;
                end
            end
            S_CONV_L: begin
                bcd_d     = bcd_next;
                shift_d   = {shift_q[4:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    // Park the left result and restart the engine on R.
                    l_bcd_d   = bcd_next;
                    bcd_d     = 8'd0;
                    shift_d   = r_snap_q;
                    bit_cnt_d = 3'd0;
                    state_d   = S_CONV_R;
                end
            end
            S_CONV_R: begin
                bcd_d     = bcd_next;
                shift_d   = {shift_q[4:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                d3_d    = l_bcd_q[7:4];
                d2_d    = l_bcd_q[3:0];
                d1_d    = bcd_q[7:4];
                d0_d    = bcd_q[3:0];
                colon_d = colon_snap_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output stage, registered below
        case (digit_idx_q)
            2'd0:    cur_nibble = d0_q;
            2'd1:    cur_nibble = d1_q;
            2'd2:    cur_nibble = d2_q;
            default: cur_nibble = d3_q;
        endcase

        if (valid_q) begin
            sel_d = ~(4'b0001 << digit_idx_q);
            seg_d = seg_decode(cur_nibble);
            if ((digit_idx_q == 2'd2) && colon_q) begin
                seg_d[7] = 1'b0;
            end
            if (LEAD_BLANK && (digit_idx_q == 2'd3) && (d3_q == 4'd0)) begin
                seg_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            scan_cnt_q   <= '0;
            digit_idx_q  <= 2'd0;
            shift_q      <= 6'd0;
            r_snap_q     <= 6'd0;
            colon_snap_q <= 1'b0;
            bcd_q        <= 8'd0;
            l_bcd_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            d3_q         <= 4'd0;
            d2_q         <= 4'd0;
            d1_q         <= 4'd0;
            d0_q         <= 4'd0;
            colon_q      <= 1'b0;
            valid_q      <= 1'b0;
            seg_q        <= 8'hFF;
            sel_q        <= 4'b1111;
        end else begin
            state_q      <= state_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            shift_q      <= shift_d;
            r_snap_q     <= r_snap_d;
            colon_snap_q <= colon_snap_d;
            bcd_q        <= bcd_d;
            l_bcd_q      <= l_bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            d3_q         <= d3_d;
            d2_q         <= d2_d;
            d1_q         <= d1_d;
            d0_q         <= d0_d;
            colon_q      <= colon_d;
            valid_q      <= valid_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
        end
    end

    assign SegmentDrivers = seg_q;
    assign SegmentSelect  = sel_q;

endmodule

// File: tb/tb_wall_clock_display.sv
// -----------------------------------------------------------------------------
// tb_wall_clock_display
//
// Two instances (LEAD_BLANK = 0 and 1) share all inputs and run in lockstep.
// Each displayed frame's expected digit slots are queued when the frame is
// set up; a monitor pops one entry at the end of each non-blank digit slot.
// With SCAN_DIV=16 a frame is 64 cycles and frame starts fall on cycles
// release+64k.
// -----------------------------------------------------------------------------
module tb_wall_clock_display;

    localparam int FRAME = 64;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] seconds = 6'd0;
    logic [5:0] minutes = 6'd0;
    logic [4:0] hours   = 5'd0;
    logic       show_seconds = 1'b0;
    logic [7:0] seg0, seg1;
    logic [3:0] sel0, sel1;

    always #5 Clock = ~Clock;

    wall_clock_display #(.SCAN_DIV(16), .LEAD_BLANK(1'b0)) dut0 (
        .Clock          (Clock),
        .reset          (reset),
        .seconds        (seconds),
        .minutes        (minutes),
        .hours          (hours),
        .show_seconds   (show_seconds),
        .SegmentDrivers (seg0),
        .SegmentSelect  (sel0)
    );

    wall_clock_display #(.SCAN_DIV(16), .LEAD_BLANK(1'b1)) dut1 (
        .Clock          (Clock),
        .reset          (reset),
        .seconds        (seconds),
        .minutes        (minutes),
        .hours          (hours),
        .show_seconds   (show_seconds),
        .SegmentDrivers (seg1),
        .SegmentSelect  (sel1)
    );

    typedef struct {
        int         digit;
        logic [3:0] sel;
        logic [7:0] seg0;
        logic [7:0] seg1;
    } exp_t;

    exp_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int r_cyc        = 0;

    logic [3:0] p_sel0 = 4'b1111;
    logic [3:0] p_sel1 = 4'b1111;
    logic [7:0] p_seg0 = 8'hFF;
    logic [7:0] p_seg1 = 8'hFF;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int n);
        case (n)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic push_frame(input int h, input int m, input int s, input logic show);
        int   l, r;
        logic colon;
        exp_t e;
        l     = show ? m : h;
        r     = show ? s : m;
        colon = ((s % 2) == 0);
        e.digit = 0; e.sel = 4'b1110; e.seg0 = seg_of(r % 10); e.seg1 = e.seg0;
        exp_q.push_back(e);
        e.digit = 1; e.sel = 4'b1101; e.seg0 = seg_of(r / 10); e.seg1 = e.seg0;
        exp_q.push_back(e);
        e.digit = 2; e.sel = 4'b1011;
        e.seg0 = seg_of(l % 10) & (colon ? 8'h7F : 8'hFF); e.seg1 = e.seg0;
        exp_q.push_back(e);
        e.digit = 3; e.sel = 4'b0111; e.seg0 = seg_of(l / 10);
        e.seg1 = ((l / 10) == 0) ? 8'hFF : e.seg0;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int h, input int m, input int s, input logic show);
        hours        = 5'(h);
        minutes      = 6'(m);
        seconds      = 6'(s);
        show_seconds = show;
    endtask

    // Returns at the negedge following edge release+64k+off.
    task automatic wait_offset(input int off);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge Clock);
            if (((cyc - r_cyc) % FRAME) == off) return;
        end
    endtask

    // Post-release window: blank through release+13, digit 0 at release+14.
    task automatic check_restart(input string tag, input logic [7:0] digit0_seg);
        for (int k = 0; k < 14; k++) begin
            @(negedge Clock);
            check_eq($sformatf("%s_blank_seg_%0d", tag, k), seg0, 8'hFF);
            check_eq($sformatf("%s_blank_sel_%0d", tag, k), sel0, 4'b1111);
        end
        @(negedge Clock);
        check_eq($sformatf("%s_first_seg", tag), seg0, digit0_seg);
        check_eq($sformatf("%s_first_sel", tag), sel0, 4'b1110);
    endtask

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    // Scoreboard monitor: a slot ends when the select changes away from a
    // non-blank value; the last sample of that slot is compared.
    initial forever begin
        exp_t e;
        @(negedge Clock);
        if ((sel0 !== p_sel0) && (p_sel0 !== 4'b1111) && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            check_eq($sformatf("d%0d_sel0", e.digit), p_sel0, e.sel);
            check_eq($sformatf("d%0d_sel1", e.digit), p_sel1, e.sel);
            check_eq($sformatf("d%0d_seg0", e.digit), p_seg0, e.seg0);
            check_eq($sformatf("d%0d_seg1", e.digit), p_seg1, e.seg1);
        end
        p_sel0 = sel0;
        p_sel1 = sel1;
        p_seg0 = seg0;
        p_seg1 = seg1;
    end

    initial begin
        drive(13, 45, 20, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_eq("rst_seg0", seg0, 8'hFF);
        check_eq("rst_sel0", sel0, 4'b1111);
        check_eq("rst_seg1", seg1, 8'hFF);
        check_eq("rst_sel1", sel1, 4'b1111);
        reset = 1'b0;
        r_cyc = cyc + 1;
        push_frame(13, 45, 20, 1'b0);
        check_restart("rel1", 8'h92);

        // MM:SS with odd seconds: colon off
        wait_offset(60); drive(13, 59, 7, 1'b1);
        wait_offset(4);  push_frame(13, 59, 7, 1'b1);

        // Input change mid-conversion only shows on the following frame
        wait_offset(60); drive(13, 45, 20, 1'b0);
        wait_offset(3);  minutes = 6'd46;
        wait_offset(4);  push_frame(13, 45, 20, 1'b0);
        wait_offset(4);  push_frame(13, 46, 20, 1'b0);

        // Leading zero: blanked only on the LEAD_BLANK instance
        wait_offset(60); drive(0, 5, 20, 1'b0);
        wait_offset(4);  push_frame(0, 5, 20, 1'b0);

        // Out-of-range values shown as-is
        wait_offset(60); drive(31, 63, 33, 1'b0);
        wait_offset(4);  push_frame(31, 63, 33, 1'b0);

        // Reset in the middle of a conversion
        wait_offset(60); drive(9, 8, 2, 1'b0);
        wait_offset(5);
        reset = 1'b1;
        @(negedge Clock);
        check_eq("midrst_seg0", seg0, 8'hFF);
        check_eq("midrst_sel0", sel0, 4'b1111);
        check_eq("midrst_seg1", seg1, 8'hFF);
        check_eq("midrst_sel1", sel1, 4'b1111);
        @(negedge Clock);
        reset = 1'b0;
        r_cyc = cyc + 1;
        push_frame(9, 8, 2, 1'b0);
        check_restart("rel2", 8'h80);

        for (int i = 0; i < 3 * FRAME; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge Clock);
        end
        check_eq("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
